fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side pointer/flag controller of the async FIFO. Runs in the write clock domain.
//  - Drives the write address and write enable of the dual-port FIFO memory.
//  - Publishes a registered Gray write pointer to the write->read synchronizer.
//  - Raises a registered full flag from the read pointer synchronized into this domain.
//  It is the upstream counterpart of the read-side controller.
// PARAMETERS
//  ADDR_WIDTH  3  memory address bits; FIFO depth = 2**ADDR_WIDTH
//  AF_MARGIN   2  almost-full threshold: asserted when free slots <= AF_MARGIN (FIFO_WR_LEVEL_EN only)
// PORTS
//  W_CLK        in   1             write-domain clock, rising edge
//  W_RST        in   1             asynchronous active-low reset
//  W_INC        in   1             write request from producer
//  wq2_rptr     in   ADDR_WIDTH+1  Gray read pointer, already double-flop synchronized to W_CLK
//  wfull        out  1             FIFO full, registered
//  wclken       out  1             memory write enable = W_INC & ~wfull, combinational
//  waddr        out  ADDR_WIDTH    memory write address = wbin[ADDR_WIDTH-1:0]
//  wptr         out  ADDR_WIDTH+1  Gray write pointer, registered, to synchronizer
//  woverflow    out  1             sticky: a write was attempted while full
//  wlevel       out  ADDR_WIDTH+1  occupancy seen from write side (FIFO_WR_LEVEL_EN only)
//  walmost_full out  1             almost-full (FIFO_WR_LEVEL_EN only)
// BEHAVIOUR
//  - Single clock W_CLK. W_RST is asynchronous, active-low.
//  - Reset: wbin=0, wptr=0, wfull=0, woverflow=0. As a result waddr=0 and wclken=0.
//  - Internal binary pointer wbin, ADDR_WIDTH+1 bits:
//    - wbin_next = wbin + (W_INC & ~wfull).
//    - wgray_next = wbin_next ^ (wbin_next >> 1).
//  - Every rising edge of W_CLK: wbin <= wbin_next; wptr <= wgray_next.
//    wptr is flop-driven, so only one bit changes per increment.
//  - Full detection: wfull <= (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
//    - Full therefore asserts on the same edge that writes the last free slot.
//  - Write while full: W_INC=1 with wfull=1
//    - is dropped: wbin/wptr hold and wclken=0;
//    - sets woverflow at the next edge. woverflow clears only on reset.
//  - Wrap-around: wbin rolls over from 2**(A+1)-1 to 0, and wptr rolls over with it; no special case.
//  - Simultaneous write and read-pointer change in the same cycle: full is evaluated against
//    wgray_next and the current wq2_rptr. Because the read pointer is seen late, full is
//    pessimistic only, never optimistic.
//  - Deassertion latency: wfull drops at the first W_CLK edge after wq2_rptr advances.
//  - Reset asserted mid-operation: all state clears immediately and asynchronously;
//    wclken drops at once, and any write in flight is lost.
//  - Pointer width is A+1 bits. The extra MSB distinguishes full from empty.
// CONFIGURATION
//  Macro FIFO_WR_LEVEL_EN.
//  - When defined, the wlevel and walmost_full ports exist:
//    - rbin = Gray-to-binary conversion of wq2_rptr (XOR prefix from the MSB).
//    - wlevel = wbin - rbin, modulo 2**(A+1), combinational, range 0..2**A.
//    - walmost_full = (wlevel >= 2**A - AF_MARGIN), combinational.
//  - When undefined, these ports and all associated logic are absent.
//    The behaviour of all other ports is identical in both builds.
// TESTING (ADDR_WIDTH=3, AF_MARGIN=2)
//  1. Reset, then release -> wptr=0000, waddr=0, wfull=0, wclken=0, woverflow=0.
//  2. Hold wq2_rptr=0000 and pulse W_INC for 8 cycles:
//     - waddr steps 0..7 and wptr steps through 0001,0011,...,0100;
//     - on the 8th edge: wptr=1100, wfull=1, waddr=0.
//  3. Full with W_INC=1 for 2 cycles -> wclken=0, wptr stays 1100, woverflow=1 and stays 1.
//  4. From full, set wq2_rptr=0001 -> wfull=0 at the next edge; one further write makes wptr=1101 and wfull=1 again.
//  5. Wrap: 16 writes, with wq2_rptr tracking and kept 4 behind -> wptr returns to 0000, waddr to 0, and wfull never asserts.
//  6. LEVEL_EN build, wq2_rptr=0000 and 6 writes -> wlevel=6, walmost_full=1; at 5 writes walmost_full=0.
//     Reset asserted after 3 writes -> all outputs 0 asynchronously, and wlevel=0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer/flag controller of the async FIFO (W_CLK domain).
// Drives the memory write address/enable, publishes a registered Gray write pointer
// and raises a registered full flag against the synchronized Gray read pointer.
// Optional build macro FIFO_WR_LEVEL_EN adds the wlevel and walmost_full ports.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wfull,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
`ifdef FIFO_WR_LEVEL_EN
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  walmost_full,
`endif
  output logic                  woverflow
);

  // Elaboration-time sanity checks on the configuration.
  if (ADDR_WIDTH < 2) begin : g_bad_width
    $error("fifo_wr_ctrl: ADDR_WIDTH must be at least 2");
  end
  if (AF_MARGIN < 0 || AF_MARGIN > (1 << ADDR_WIDTH)) begin : g_bad_margin
    $error("fifo_wr_ctrl: AF_MARGIN must lie in 0..2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic                full_next;

  // Next binary/Gray pointer and full condition; wclken is also gated by the
  // reset input so the memory write enable drops the instant reset asserts.
  always_comb begin
    wclken     = W_INC & ~wfull & W_RST;
    wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wclken};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_next  = (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                 wq2_rptr[ADDR_WIDTH-2:0]});
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Pointer, full and sticky overflow registers.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr      <= wgray_next;
      wfull     <= full_next;
      woverflow <= woverflow | (W_INC & wfull);
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AF_LEVEL =
    (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - AF_MARGIN);

  logic [ADDR_WIDTH:0] rbin;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all bits at or above i.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Occupancy as seen from the write side and the almost-full threshold.
  always_comb begin
    wlevel       = wbin - rbin;
    walmost_full = (wlevel >= AF_LEVEL);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed bench for fifo_wr_ctrl (ADDR_WIDTH=3, AF_MARGIN=2).
// Define FIFO_WR_LEVEL_EN for both files to exercise the level outputs.
module tb_fifo_wr_ctrl;

  localparam int A = 3;

  logic         W_CLK;
  logic         W_RST;
  logic         W_INC;
  logic [A:0]   wq2_rptr;
  logic         wfull;
  logic         wclken;
  logic [A-1:0] waddr;
  logic [A:0]   wptr;
  logic         woverflow;
`ifdef FIFO_WR_LEVEL_EN
  logic [A:0]   wlevel;
  logic         walmost_full;
`endif

  fifo_wr_ctrl #(.ADDR_WIDTH(A), .AF_MARGIN(2)) dut (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .W_INC       (W_INC),
    .wq2_rptr    (wq2_rptr),
    .wfull       (wfull),
    .wclken      (wclken),
    .waddr       (waddr),
    .wptr        (wptr),
`ifdef FIFO_WR_LEVEL_EN
    .wlevel      (wlevel),
    .walmost_full(walmost_full),
`endif
    .woverflow   (woverflow)
  );

  initial begin
    W_CLK = 1'b0;
    forever #5 W_CLK = ~W_CLK;
  end

  typedef struct {
    logic [A:0]   wptr;
    logic [A-1:0] waddr;
    logic         wfull;
    logic         wovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [A:0] m_bin;
  logic       m_full;
  logic       m_ovf;

  function automatic logic [A:0] gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [A:0] g2b(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_bin  = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock of stimulus: drive, check combinational outputs, predict, clock, compare.
  task automatic step(input logic inc, input logic [A:0] rptr);
    logic       wr;
    logic [A:0] nb;
    logic [A:0] occ;
    exp_t       e;
    exp_t       got;
    W_INC    = inc;
    wq2_rptr = rptr;
    #1;
    check("wclken", {31'b0, wclken}, {31'b0, inc & ~m_full});
`ifdef FIFO_WR_LEVEL_EN
    occ = m_bin - g2b(rptr);
    check("wlevel", {28'b0, wlevel}, {28'b0, occ});
    check("walmost_full", {31'b0, walmost_full}, {31'b0, occ >= 4'd6});
`endif
    wr     = inc & ~m_full;
    nb     = m_bin + {3'b0, wr};
    m_ovf  = m_ovf | (inc & m_full);
    occ    = nb - g2b(rptr);
    m_full = (occ == 4'd8);
    m_bin  = nb;
    e.wptr  = gray(nb);
    e.waddr = nb[A-1:0];
    e.wfull = m_full;
    e.wovf  = m_ovf;
    sb.push_back(e);
    @(posedge W_CLK);
    #1;
    got = sb.pop_front();
    check("wptr", {28'b0, wptr}, {28'b0, got.wptr});
    check("waddr", {29'b0, waddr}, {29'b0, got.waddr});
    check("wfull", {31'b0, wfull}, {31'b0, got.wfull});
    check("woverflow", {31'b0, woverflow}, {31'b0, got.wovf});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"}, {28'b0, wptr}, 32'd0);
    check({tag, "_waddr"}, {29'b0, waddr}, 32'd0);
    check({tag, "_wfull"}, {31'b0, wfull}, 32'd0);
    check({tag, "_wclken"}, {31'b0, wclken}, 32'd0);
    check({tag, "_woverflow"}, {31'b0, woverflow}, 32'd0);
`ifdef FIFO_WR_LEVEL_EN
    check({tag, "_wlevel"}, {28'b0, wlevel}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    W_RST    = 1'b0;
    W_INC    = 1'b0;
    wq2_rptr = '0;
    model_reset();
    repeat (2) @(posedge W_CLK);
    @(negedge W_CLK);
    W_RST = 1'b1;
    @(posedge W_CLK);
    #1;
  endtask

  initial begin
    W_RST    = 1'b0;
    W_INC    = 1'b0;
    wq2_rptr = '0;
    model_reset();

    // 1. Reset state, during and after reset
    #12;
    check_all_zero("in_reset");
    @(negedge W_CLK);
    W_RST = 1'b1;
    @(posedge W_CLK);
    #1;
    check_all_zero("after_reset");

    // 2. Eight writes with the read pointer parked at zero
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000);
    check("fill_wptr", {28'b0, wptr}, 32'hC);
    check("fill_wfull", {31'b0, wfull}, 32'd1);
    check("fill_waddr", {29'b0, waddr}, 32'd0);

    // 3. Writes while full are dropped and set the sticky overflow
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
    check("ovf_wptr", {28'b0, wptr}, 32'hC);
    check("ovf_sticky", {31'b0, woverflow}, 32'd1);

    // 4. Read pointer advances: full clears, one write refills
    step(1'b0, 4'b0001);
    check("unfull_wfull", {31'b0, wfull}, 32'd0);
    step(1'b1, 4'b0001);
    check("refill_wptr", {28'b0, wptr}, 32'hD);
    check("refill_wfull", {31'b0, wfull}, 32'd1);

    // 5. Wrap: 16 writes with the reader tracking 4 behind
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, gray(m_bin - 4'd4));
    check("wrap_wptr", {28'b0, wptr}, 32'd0);
    check("wrap_waddr", {29'b0, waddr}, 32'd0);
    check("wrap_wfull", {31'b0, wfull}, 32'd0);
    check("wrap_woverflow", {31'b0, woverflow}, 32'd0);

    // 6. Asynchronous reset in the middle of writing
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
    check("pre_rst_waddr", {29'b0, waddr}, 32'd3);
    W_INC = 1'b1;
    #2;
    W_RST = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    W_INC = 1'b0;
    @(negedge W_CLK);
    W_RST = 1'b1;
    @(posedge W_CLK);
    #1;
    check_all_zero("post_async_rst");

`ifdef FIFO_WR_LEVEL_EN
    // 7. Level and almost-full thresholds
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000);
    #1;
    check("lvl5_wlevel", {28'b0, wlevel}, 32'd5);
    check("lvl5_af", {31'b0, walmost_full}, 32'd0);
    step(1'b1, 4'b0000);
    #1;
    check("lvl6_wlevel", {28'b0, wlevel}, 32'd6);
    check("lvl6_af", {31'b0, walmost_full}, 32'd1);
    step(1'b0, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
